// File: rtl/call_input_conditioner.sv
// Button front end: per-channel synchroniser, debounce counter, clean level,
// rising-edge pulse and a sticky request bit that the controller clears.
module call_input_conditioner #(
  parameter int WIDTH           = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] btn_raw,
  input  logic [WIDTH-1:0] clr,
  output logic [WIDTH-1:0] btn_level,
  output logic [WIDTH-1:0] btn_rise,
  output logic [WIDTH-1:0] req_latched
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_stage_reg;
  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] accept;
  logic [WIDTH-1:0] level_next;
  logic [WIDTH-1:0] rise_next;
  logic [WIDTH-1:0] req_next;

  assign sync = sync_stage_reg[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_stage_reg <= '0;
    end else begin
      sync_stage_reg <= {sync_stage_reg[SYNC_STAGES-2:0], btn_raw};
    end
  end

  // One independent counter per channel; any agreement restarts the count.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chan
      logic [CNT_W-1:0] cnt_reg;
      logic             differ;

      assign differ     = sync[gi] ^ btn_level[gi];
      assign accept[gi] = differ && (cnt_reg == CNT_LAST);

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cnt_reg <= '0;
        end else if (!differ || accept[gi]) begin
          cnt_reg <= '0;
        end else begin
          cnt_reg <= cnt_reg + CNT_W'(1);
        end
      end
    end
  endgenerate

  // The pulse register also counts as a set term so a clear landing in the
  // pulse cycle cannot drop a request that has just been raised.
  always_comb begin
    level_next = btn_level ^ accept;
    rise_next  = accept & sync;
    req_next   = rise_next | btn_rise | (req_latched & ~clr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_level   <= '0;
      btn_rise    <= '0;
      req_latched <= '0;
    end else begin
      btn_level   <= level_next;
      btn_rise    <= rise_next;
      req_latched <= req_next;
    end
  end

endmodule

// File: tb/tb_call_input_conditioner.sv
// Randomised and directed bench for call_input_conditioner against a
// window-based reference model of the debounce rules.
module tb_call_input_conditioner;

  localparam int W  = 4;
  localparam int SS = 2;
  localparam int DC = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] btn_raw;
  logic [W-1:0] clr;
  logic [W-1:0] btn_level;
  logic [W-1:0] btn_rise;
  logic [W-1:0] req_latched;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: raw samples per edge, sync values seen per edge.
  logic [W-1:0] hist[$];
  logic [W-1:0] synch[$];
  logic [W-1:0] m_level, m_rise, m_req;

  call_input_conditioner #(
    .WIDTH(W), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DC)
  ) dut (
    .clk(clk), .rst(rst), .btn_raw(btn_raw), .clr(clr),
    .btn_level(btn_level), .btn_rise(btn_rise), .req_latched(req_latched)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic model_reset();
    hist.delete();
    synch.delete();
    for (int i = 0; i < SS; i++) hist.push_back('0);
    for (int i = 0; i < DC; i++) synch.push_back('0);
    m_level = '0;
    m_rise  = '0;
    m_req   = '0;
  endtask

  // A channel accepts a new level once the last DC synchronised samples
  // all disagree with the level it currently reports.
  task automatic model_step();
    logic [W-1:0] s, flip, nrise;
    s = hist[hist.size() - SS];
    synch.push_back(s);
    flip = '1;
    for (int ch = 0; ch < W; ch++)
      for (int i = 0; i < DC; i++)
        if (synch[synch.size() - 1 - i][ch] == m_level[ch]) flip[ch] = 1'b0;
    nrise   = flip & s;
    m_req   = nrise | m_rise | (m_req & ~clr);
    m_rise  = nrise;
    m_level = m_level ^ flip;
    hist.push_back(btn_raw);
    if (hist.size() > 64) void'(hist.pop_front());
    if (synch.size() > 64) void'(synch.pop_front());
  endtask

  task automatic tick(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check({tag, "_level"}, btn_level, m_level);
    check({tag, "_rise"}, btn_rise, m_rise);
    check({tag, "_req"}, req_latched, m_req);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_level"}, btn_level, 4'h0);
    check({tag, "_rise"}, btn_rise, 4'h0);
    check({tag, "_req"}, req_latched, 4'h0);
  endtask

  // Asynchronous reset pulse starting between edges, held across one edge.
  task automatic reset_pulse(input string tag);
    #3 rst = 1'b1;
    #1 check_zero({tag, "_async"});
    model_reset();
    @(posedge clk);
    #1 check_zero({tag, "_held"});
    rst = 1'b0;
  endtask

  int rise_cnt, rise_at;

  initial begin
    rst     = 1'b1;
    btn_raw = 4'hF;
    clr     = 4'h0;
    model_reset();

    // 1: outputs stay zero throughout reset with inputs high
    #1 check_zero("t1_t0");
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1 check_zero("t1_rst");
    end
    btn_raw = 4'h0;
    rst     = 1'b0;
    model_reset();
    for (int i = 0; i < 8; i++) tick("t1_idle");

    // 2: press channel 0, hold 20 cycles, then release
    btn_raw[0] = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick("t2_press");
      if (i == 5) check("t2_lvl_e5", btn_level, 4'b0000);
      if (i == 6) begin
        check("t2_lvl_e6", btn_level, 4'b0001);
        check("t2_rise_e6", btn_rise, 4'b0001);
        check("t2_req_e6", req_latched, 4'b0001);
      end
      if (i == 7) check("t2_rise_e7", btn_rise, 4'b0000);
    end
    btn_raw[0] = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick("t2_rel");
      if (i == 5) check("t2_rel_e5", btn_level, 4'b0001);
      if (i == 6) begin
        check("t2_rel_e6", btn_level, 4'b0000);
        check("t2_rel_rise", btn_rise, 4'b0000);
        check("t2_rel_req", req_latched, 4'b0001);
      end
    end

    // 5: clear, re-press, clear during pulse (set wins), then clear again
    clr = 4'b0001;
    tick("t5_clr");
    check("t5_cleared", req_latched, 4'b0000);
    clr = 4'b0000;
    btn_raw[0] = 1'b1;
    for (int i = 1; i <= 6; i++) tick("t5_press");
    check("t5_rise", btn_rise, 4'b0001);
    clr = 4'b0001;
    tick("t5_same");
    check("t5_setwins", req_latched, 4'b0001);
    tick("t5_next");
    check("t5_clr2", req_latched, 4'b0000);
    check("t5_lvl_kept", btn_level, 4'b0001);
    clr = 4'b0000;

    // 3: short 3-cycle blip on channel 1 is rejected
    btn_raw[1] = 1'b1;
    for (int i = 0; i < 3; i++) tick("t3_blip");
    btn_raw[1] = 1'b0;
    for (int i = 0; i < 10; i++) tick("t3_after");
    check("t3_lvl", btn_level, 4'b0001);

    // 4: bouncing channel 2 gives exactly one pulse, 6 edges after last rise
    rise_cnt = 0;
    rise_at  = -1;
    for (int i = 1; i <= 20; i++) begin
      btn_raw[2] = (i <= 5) ? ((i % 2) == 1) : 1'b1;
      tick("t4_bounce");
      if (btn_rise[2]) begin
        rise_cnt++;
        rise_at = i;
      end
    end
    check("t4_count", W'(rise_cnt), W'(1));
    check("t4_when", W'(rise_at), W'(10));

    // 6: reset mid-count on channel 3, input held through release
    btn_raw = 4'b1000;
    for (int i = 0; i < 4; i++) tick("t6_count");
    reset_pulse("t6");
    for (int i = 1; i <= 6; i++) begin
      tick("t6_after");
      if (i == 5) check("t6_rise_e5", btn_rise, 4'b0000);
      if (i == 6) check("t6_rise_e6", btn_rise, 4'b1000);
    end

    // Random phase: sticky inputs with occasional toggles and glitches
    for (int n = 0; n < 600; n++) begin
      for (int ch = 0; ch < W; ch++)
        if ($urandom_range(5) == 0) btn_raw[ch] = ~btn_raw[ch];
      clr = 4'($urandom) & 4'($urandom);
      if (n == 300) reset_pulse("rnd");
      tick("rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
